// File: rtl/fractal_iter_engine_pkg.sv
// Shared types and fixed-point helpers for the fractal escape-time engine.
// The helpers work on 32-bit operands, so word widths up to 32 bits are supported.
package fractal_iter_engine_pkg;

  localparam int unsigned WsDef = 16;
  localparam int unsigned DpDef = 8;

  typedef struct packed {
    logic signed [WsDef-1:0] im;
    logic signed [WsDef-1:0] re;
  } cplx_t;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

  // Real part of z^2: each product is rescaled before the subtraction.
  function automatic logic signed [63:0] cplx_sq_re(input logic signed [31:0] re,
                                                    input logic signed [31:0] im,
                                                    input int unsigned dp);
    logic signed [63:0] rr;
    logic signed [63:0] ii;
    rr = 64'(re) * 64'(re);
    ii = 64'(im) * 64'(im);
    return (rr >>> dp) - (ii >>> dp);
  endfunction

  function automatic logic signed [63:0] cplx_sq_im(input logic signed [31:0] re,
                                                    input logic signed [31:0] im,
                                                    input int unsigned dp);
    logic signed [63:0] ri;
    ri = 64'(re) * 64'(im);
    return (ri >>> dp) <<< 1;
  endfunction

  // Unshifted |z|^2, so the result carries 2*dp fractional bits.
  function automatic logic [64:0] abs_sq(input logic signed [31:0] re,
                                         input logic signed [31:0] im);
    logic signed [63:0] rr;
    logic signed [63:0] ii;
    rr = 64'(re) * 64'(re);
    ii = 64'(im) * 64'(im);
    return {1'b0, rr} + {1'b0, ii};
  endfunction

endpackage

// File: rtl/fractal_iter_engine_if.sv
// Pixel request / result handshake bundle between the coordinate generator,
// the escape-time engine and the colour-map stage.
interface fractal_iter_engine_if #(
  parameter int unsigned ws     = 16,
  parameter int unsigned iterws = 5
) ();

  logic              iValid;
  logic              oReady;
  logic [ws-1:0]     x;
  logic [ws-1:0]     y;
  logic [2*ws-1:0]   c;
  logic [ws-1:0]     thres;
  logic              mode;
  logic              oValid;
  logic              iReady;
  logic [iterws-1:0] oIterCnt;
  logic [ws-1:0]     oX;
  logic [ws-1:0]     oY;

  modport master (
    output iValid, x, y, c, thres, mode, iReady,
    input  oReady, oValid, oIterCnt, oX, oY
  );

  modport slave (
    input  iValid, x, y, c, thres, mode, iReady,
    output oReady, oValid, oIterCnt, oX, oY
  );

endinterface

// File: rtl/fix_complex_sqadd.sv
// Combinational z^2 + c step plus the full-precision escape test |z|^2 > thres * 2^dp.
module fix_complex_sqadd
  import fractal_iter_engine_pkg::*;
#(
  parameter int unsigned ws = 16,
  parameter int unsigned dp = 8
) (
  input  logic signed [ws-1:0] z_re,
  input  logic signed [ws-1:0] z_im,
  input  logic signed [ws-1:0] c_re,
  input  logic signed [ws-1:0] c_im,
  input  logic        [ws-1:0] thres,
  output logic signed [ws-1:0] nxt_re,
  output logic signed [ws-1:0] nxt_im,
  output logic                 escape
);

  // Wide enough for both 2ws+1-bit |z|^2 and the shifted threshold.
  localparam int unsigned CmpW = 2 * ws + 1 + dp;

  logic [CmpW-1:0] lim;

  always_comb begin
    nxt_re = ws'(cplx_sq_re(32'(z_re), 32'(z_im), dp)) + c_re;
    nxt_im = ws'(cplx_sq_im(32'(z_re), 32'(z_im), dp)) + c_im;
    lim    = CmpW'(thres) << dp;
    escape = CmpW'(abs_sq(32'(z_re), 32'(z_im))) > lim;
  end

endmodule

// File: rtl/fractal_iter_engine.sv
// Sequential Julia/Mandelbrot escape-time engine: one z <- z^2 + c step per clock
// on a shared datapath, returning a binary iteration count per accepted pixel.
module fractal_iter_engine
  import fractal_iter_engine_pkg::*;
#(
  parameter int unsigned ws      = 16,
  parameter int unsigned dp      = 8,
  parameter int unsigned maxIter = 23,
  parameter int unsigned iterws  = $clog2(maxIter + 1),
  parameter int unsigned xOff    = 640,
  parameter int unsigned yOff    = 360
) (
  input logic                  iClk,
  input logic                  iRst_n,
  fractal_iter_engine_if.slave bus
);

  state_e             state_q, state_d;
  logic  [iterws-1:0] k_q, k_d;
  logic  [iterws-1:0] cnt_q, cnt_d;
  logic signed [ws-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic signed [ws-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
  logic  [ws-1:0]     thres_q, thres_d;
  logic  [ws-1:0]     ox_q, ox_d, oy_q, oy_d;
  logic               ready_q;

  logic signed [ws-1:0] p_re, p_im;
  logic signed [ws-1:0] nxt_re, nxt_im;
  logic                 escape;

  fix_complex_sqadd #(
    .ws(ws),
    .dp(dp)
  ) u_sqadd (
    .z_re  (z_re_q),
    .z_im  (z_im_q),
    .c_re  (c_re_q),
    .c_im  (c_im_q),
    .thres (thres_q),
    .nxt_re(nxt_re),
    .nxt_im(nxt_im),
    .escape(escape)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    z_re_d  = z_re_q;
    z_im_d  = z_im_q;
    c_re_d  = c_re_q;
    c_im_d  = c_im_q;
    thres_d = thres_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    p_re    = bus.x - ws'(xOff);
    p_im    = bus.y - ws'(yOff);

    unique case (state_q)
      StIdle: begin
        if (bus.iValid) begin
          ox_d    = bus.x;
          oy_d    = bus.y;
          thres_d = bus.thres;
          k_d     = '0;
          state_d = StIter;
          if (bus.mode) begin
            z_re_d = '0;
            z_im_d = '0;
            c_re_d = p_re;
            c_im_d = p_im;
          end else begin
            z_re_d = p_re;
            z_im_d = p_im;
            c_re_d = bus.c[ws-1:0];
            c_im_d = bus.c[2*ws-1:ws];
          end
        end
      end
      StIter: begin
        if (escape) begin
          cnt_d   = k_q;
          state_d = StDone;
        end else if (k_q == iterws'(maxIter - 1)) begin
          cnt_d   = iterws'(maxIter);
          state_d = StDone;
        end else begin
          z_re_d = nxt_re;
          z_im_d = nxt_im;
          k_d    = k_q + iterws'(1);
        end
      end
      StDone: begin
        if (bus.iReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // oReady is registered so it stays low while reset is asserted.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      z_re_q  <= '0;
      z_im_q  <= '0;
      c_re_q  <= '0;
      c_im_q  <= '0;
      thres_q <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      z_re_q  <= z_re_d;
      z_im_q  <= z_im_d;
      c_re_q  <= c_re_d;
      c_im_q  <= c_im_d;
      thres_q <= thres_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ready_q <= (state_d == StIdle);
    end
  end

  assign bus.oReady   = ready_q;
  assign bus.oValid   = (state_q == StDone);
  assign bus.oIterCnt = cnt_q;
  assign bus.oX       = ox_q;
  assign bus.oY       = oy_q;

endmodule

// File: tb/tb_fractal_iter_engine.sv
// Scoreboard bench for fractal_iter_engine: directed pixels push expected results,
// an independent monitor compares every presented result, its latency and handshake.
module tb_fractal_iter_engine;
  import fractal_iter_engine_pkg::*;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] c;
    logic [15:0] thres;
    logic        mode;
    int          cnt;
    int          lat;
  } vec_t;

  typedef struct {
    int cnt;
    int ox;
    int oy;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  vec_t vecs[$];
  bit   prev_valid = 0;
  int   rise_cyc = 0;

  fractal_iter_engine_if #(.ws(16), .iterws(5)) bus ();

  fractal_iter_engine #(
    .ws(16), .dp(8), .maxIter(23), .iterws(5), .xOff(640), .yOff(360)
  ) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, expv);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected event required none", name);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      acc_q.delete();
      prev_valid = 0;
    end else begin
      if (bus.oValid) begin
        if (!prev_valid) rise_cyc = cyc;
        check("ready_low_done", 64'(bus.oReady), 64'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_valid");
        end else begin
          check("iter_cnt", 64'(bus.oIterCnt), 64'(exp_q[0].cnt));
          check("out_x", 64'(bus.oX), 64'(exp_q[0].ox));
          check("out_y", 64'(bus.oY), 64'(exp_q[0].oy));
        end
        if (bus.iReady) begin
          if (acc_q.size() == 0) fail_now("no_accept_for_result");
          else if (exp_q.size() != 0)
            check("latency", 64'(rise_cyc - acc_q[0]), 64'(exp_q[0].lat));
          if (acc_q.size() != 0) void'(acc_q.pop_front());
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end else if (acc_q.size() != 0) begin
        check("ready_low_iter", 64'(bus.oReady), 64'd0);
      end
      if (bus.iValid && bus.oReady) acc_q.push_back(cyc + 1);
      prev_valid = bus.oValid;
    end
  end

  task automatic send(input vec_t v, input bit expect_out);
    int n = 0;
    bus.x      = v.x;
    bus.y      = v.y;
    bus.c      = v.c;
    bus.thres  = v.thres;
    bus.mode   = v.mode;
    bus.iValid = 1'b1;
    @(negedge clk);
    while (!bus.oReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.oReady) fail_now("accept_timeout");
    else if (expect_out) exp_q.push_back('{v.cnt, int'(v.x), int'(v.y), v.lat});
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.oReady) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !bus.oReady) begin
      fail_now("result_timeout");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cplx_t ci;
    cplx_t c1;
    int    n;
    ci.im = 16'sh0100;
    ci.re = 16'sh0000;
    c1.im = 16'sh0000;
    c1.re = 16'sh0100;
    // x, y, c, thres, mode, count, latency
    vecs.push_back('{16'd640,   16'd360, 32'h0, 16'h0400, 1'b0, 23, 23});  // z0=0, never escapes
    vecs.push_back('{16'd1408,  16'd360, 32'h0, 16'h0400, 1'b0,  0,  1});  // z0=3.0
    vecs.push_back('{16'd896,   16'd360, 32'h0, 16'h0400, 1'b1,  3,  4});  // c=1.0: 0,1,2,5
    vecs.push_back('{16'd33152, 16'd360, 32'h0, 16'h7FFF, 1'b0,  0,  1});  // needs wide compare
    vecs.push_back('{16'd128,   16'd360, 32'h0, 16'h0400, 1'b1, 23, 23});  // c=-2: |z|^2 == thres
    vecs.push_back('{16'd640,   16'd360, ci,    16'h0400, 1'b0, 23, 23});  // Julia c=i
    vecs.push_back('{16'd640,   16'd360, c1,    16'h0400, 1'b0,  3,  4});  // Julia c=1.0
    vecs.push_back('{16'd896, 16'd360, 32'h1234_5678, 16'h0400, 1'b1, 3, 4});  // c ignored
    vecs.push_back('{16'd640,   16'd616, 32'h0, 16'h0400, 1'b1, 23, 23});  // Mandelbrot c=i
    vecs.push_back('{16'hFF80,  16'd360, 32'h0, 16'h0400, 1'b0,  0,  1});  // z0=-3.0

    bus.iValid = 1'b0;
    bus.x      = '0;
    bus.y      = '0;
    bus.c      = '0;
    bus.thres  = '0;
    bus.mode   = 1'b0;
    bus.iReady = 1'b1;
    rst_n      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(bus.oReady), 64'd0);
    check("reset_valid", 64'(bus.oValid), 64'd0);
    check("reset_cnt", 64'(bus.oIterCnt), 64'd0);
    check("reset_x", 64'(bus.oX), 64'd0);
    check("reset_y", 64'(bus.oY), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 64'(bus.oReady), 64'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      send(vecs[i], 1'b1);
      wait_idle();
    end

    // Backpressure: hold the result for 5 cycles while poking iValid.
    bus.iReady = 1'b0;
    send(vecs[2], 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.oValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.oValid) fail_now("bp_valid_timeout");
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.iValid = ~bus.iValid;
      bus.x      = 16'h1111;
      bus.y      = 16'h2222;
    end
    @(posedge clk);
    #1;
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    wait_idle();

    // Reset while iterating at k=5 aborts the pixel without a result.
    send(vecs[0], 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", 64'(bus.oValid), 64'd0);
    check("abort_ready_in_reset", 64'(bus.oReady), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_after", 64'(bus.oReady), 64'd1);
    check("abort_valid_after", 64'(bus.oValid), 64'd0);
    @(posedge clk);
    #1;
    send(vecs[1], 1'b1);
    wait_idle();

    repeat (30) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
